// File: rtl/soc_mem_pkg.sv
// soc_mem_pkg: shared types and constants for the data-port responder.
package soc_mem_pkg;
   typedef struct packed {
      logic valid;
      logic we;
      logic oor;
   } resp_tag_t;
   localparam logic [31:0] OOR_RDATA = 32'h0;
endpackage

// File: rtl/core_data_inf.sv
// CORE_DATA_INF: CV32E data-port bundle (OBI-style request/grant/response).
interface CORE_DATA_INF;
   logic        data_req;
   logic [31:0] data_addr;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   modport Master (output data_req, data_addr, data_we, data_be, data_wdata,
                   input  data_gnt, data_rvalid, data_rdata);
   modport Slave  (input  data_req, data_addr, data_we, data_be, data_wdata,
                   output data_gnt, data_rvalid, data_rdata);
endinterface

// File: rtl/cv32e_resp_pipe.sv
// cv32e_resp_pipe: fixed-depth delay line of response tags matching the SRAM read latency.
module cv32e_resp_pipe
   import soc_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  resp_tag_t tag_i,
   output resp_tag_t tag_o
);
   resp_tag_t pipe_q [DEPTH];
   resp_tag_t pipe_d [DEPTH];
   always_comb begin
      pipe_d[0] = tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      else       for (int i = 0; i < DEPTH; i++) pipe_q[i] <= pipe_d[i];
   end
   assign tag_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/cv32e_data_mem_responder.sv
// cv32e_data_mem_responder: data-port responder serving a synchronous SRAM with
// in-order responses and a bounded number of outstanding transactions.
module cv32e_data_mem_responder
   import soc_mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int unsigned MEM_AW          = 12,
   parameter int unsigned READ_LATENCY    = 1,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   CORE_DATA_INF.Slave       data_slave_inf,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   localparam int unsigned   CW   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] OMAX = CW'(MAX_OUTSTANDING);
   logic [CW-1:0] ocnt_q, ocnt_d;
   logic [31:0]   offs;
   logic          in_rng, xfer, rvalid;
   resp_tag_t     tag_in, tag_out;
   always_comb begin
      offs   = data_slave_inf.data_addr - BASE_ADDR;
      in_rng = (offs >> (MEM_AW + 2)) == 32'd0;
      // a response retiring this cycle frees its slot for the new grant
      xfer   = !rst_i && data_slave_inf.data_req && (ocnt_q < OMAX || rvalid);
      mem_en    = xfer && in_rng;
      mem_we    = mem_en && data_slave_inf.data_we;
      mem_be    = data_slave_inf.data_we ? data_slave_inf.data_be : 4'hF;
      mem_addr  = offs[MEM_AW+1:2];
      mem_wdata = data_slave_inf.data_wdata;
      tag_in    = '{valid: xfer, we: data_slave_inf.data_we, oor: !in_rng};
      ocnt_d = (xfer && !rvalid) ? ocnt_q + CW'(1) :
               (rvalid && !xfer) ? ocnt_q - CW'(1) : ocnt_q;
      data_slave_inf.data_gnt    = xfer;
      data_slave_inf.data_rvalid = rvalid;
      data_slave_inf.data_rdata  = (rvalid && !tag_out.we && !tag_out.oor) ? mem_rdata : OOR_RDATA;
   end
   assign rvalid = tag_out.valid;
   cv32e_resp_pipe #(.DEPTH(READ_LATENCY)) u_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .tag_i (tag_in),
      .tag_o (tag_out)
   );
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ocnt_q <= '0;
      else       ocnt_q <= ocnt_d;
   end
   a_ocnt_max: assert property (@(posedge clk_i) disable iff (rst_i) ocnt_q <= OMAX);
   a_ocnt_min: assert property (@(posedge clk_i) disable iff (rst_i) !(rvalid && !xfer && ocnt_q == '0));
endmodule
